reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port architectural register file for the RISC-V core, the successor to the single-write, two-read register file. It provides NREAD combinational read ports and NWRITE synchronous write ports, with optional write-to-read bypass and hard-wired zero register. It also carries a per-register busy scoreboard that the decode stage uses to detect RAW hazards against in-flight instructions. It sits between decode (reads, issue marking) and writeback (writes, busy clearing).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers (power of two, ≥2); AW = log2(NREGS)
- NREAD, 2, number of read ports (≥1)
- NWRITE, 2, number of write ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issue marks
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock and a synchronous active-high reset, sampled on the rising edge of clk
- rs_addr  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW]
- rs_data  out  NREAD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- rs_busy  out  NREAD  busy flag of the addressed register, per read port
- wr_en  in  NWRITE  write enables
- wr_addr  in  NWRITE*AW  write addresses
- wr_data  in  NWRITE*XLEN  write data
- issue_en  in  1  mark issue_addr busy (destination of newly issued instruction)
- issue_addr  in  AW  register to mark busy
- busy_vec  out  NREGS  full scoreboard, bit i = register i busy

## Operation
- Storage: NREGS × XLEN array plus NREGS-bit busy vector.
- Write: on each rising edge with reset low, for every port j with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
- Write conflict: two or more enabled ports with the same address means the highest-index port wins.
- Writeback clears busy. Any enabled write to register r clears busy[r] at the same edge.
- Issue: issue_en=1 sets busy[issue_addr] at the edge.
- Issue and a write to the same register in the same cycle: busy stays 1, because the newer instruction owns the register. The data write still occurs.
- ZERO_REG=1:
  - rs_data for address 0 is always 0.
  - rs_busy for address 0 is always 0, and busy_vec[0] is always 0.
  - Writes and issue marks to address 0 are discarded.
- Read (combinational) for port k with address a:
  - If BYPASS=1 and some enabled write port targets a (and a≠0 when ZERO_REG=1), output the data of the highest-index such port.
  - Otherwise output reg[a].
- rs_busy[k] is busy[a] as stored. It is not bypassed: a same-cycle writeback does not hide busy until the next cycle.
- BYPASS=0: reads return the stored value only. Written data becomes visible the cycle after the edge.
- Reset: at the edge with reset=1, all registers are set to 0 and all busy bits to 0. Reset overrides any concurrent write or issue.

## Timing
- Reads: zero-cycle combinational path from rs_addr and write ports (when BYPASS=1) to rs_data. rs_busy depends only on rs_addr and stored state.
- Writes, busy set and busy clear take effect at the rising edge. They are visible on outputs in the following cycle (BYPASS=0) or the same cycle for data (BYPASS=1).
- Reset values: rs_data=0 for all ports, rs_busy=0, busy_vec=0. These hold from the first edge with reset=1 until the next write or issue.
- Reset asserted mid-stream: inputs in that cycle are ignored. Operation resumes on the first edge with reset=0.
- No handshake: the caller guarantees port legality. There are no stalls and no output latency beyond what is stated above.

## Test plan
- Reset then read: assert reset 1 cycle after random writes. All rs_data=0 and busy_vec=0. A write of 0xDEADBEEF to x5 issued in the reset cycle is lost (x5 reads 0).
- Basic write/read: wr_en[0]=1, x7 ← 0x12345678. Next cycle, reading x7 on both ports returns 0x12345678. In the same cycle as the write, it reads 0x12345678 with BYPASS=1 and the old value 0 with BYPASS=0.
- Zero register: write 0xFFFFFFFF to x0 and issue_en on x0. x0 reads 0, rs_busy=0 and busy_vec[0]=0. With ZERO_REG=0, x0 reads 0xFFFFFFFF next cycle.
- Write conflict: port0 x3←0xAAAA, port1 x3←0x5555 in the same cycle. x3 reads 0x5555, and the same-cycle bypass also returns 0x5555.
- Scoreboard:
  - issue x9: busy_vec[9]=1 next cycle and rs_busy=1 when reading x9.
  - Write x9 on port1: busy cleared next cycle, while still 1 during the write cycle.
  - Issue x9 and write x9 in the same cycle: busy remains 1 and the data is updated.
- Parameter sweep: NREGS=64, XLEN=64, NREAD=3, NWRITE=1. Write 0x0123456789ABCDEF to x63 and read it on all three ports. busy_vec is 64 bits and resets to 0.

Source files
------------

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_file_mp_if                                                  |
// | Brief    : Decode/writeback bus of the multi-port register file.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface reg_file_mp_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NREAD*AW-1:0]    rs_addr;
   logic [NREAD*XLEN-1:0]  rs_data;
   logic [NREAD-1:0]       rs_busy;
   logic [NWRITE-1:0]      wr_en;
   logic [NWRITE*AW-1:0]   wr_addr;
   logic [NWRITE*XLEN-1:0] wr_data;
   logic                   issue_en;
   logic [AW-1:0]          issue_addr;
   logic [NREGS-1:0]       busy_vec;

   modport master (
      output rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      input  rs_data, rs_busy, busy_vec
   );

   modport slave (
      input  rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      output rs_data, rs_busy, busy_vec
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_file_mp                                                     |
// | Brief    : Multi-port register file with write bypass and busy scoreboard. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reg_file_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  wire logic        clk,
   input  wire logic        reset,
   reg_file_mp_if.slave     bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]       r_regs [NREGS];
   logic [NREGS-1:0]      r_busy;
   logic [NWRITE-1:0]     w_wr_ok;
   logic [NREGS-1:0]      w_busy_next;
   logic [NREAD*XLEN-1:0] w_rs_data;
   logic [NREAD-1:0]      w_rs_busy;

   // Writes aimed at the hard-wired zero register are dropped up front.
   always_comb begin
      w_wr_ok = '0;
      for (int j = 0; j < NWRITE; j++) begin
         w_wr_ok[j] = bus.wr_en[j] &&
                      !((ZERO_REG != 0) && (bus.wr_addr[j*AW +: AW] == '0));
      end
   end

   // Issue is applied after writeback clears so the newer instruction keeps ownership.
   always_comb begin
      w_busy_next = r_busy;
      for (int j = 0; j < NWRITE; j++) begin
         if (w_wr_ok[j]) begin
            w_busy_next[bus.wr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (bus.issue_en) begin
         w_busy_next[bus.issue_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         // Later ports overwrite earlier ones, so the highest index wins.
         for (int j = 0; j < NWRITE; j++) begin
            if (w_wr_ok[j]) begin
               r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            end
         end
         r_busy <= w_busy_next;
      end
   end

   // Busy is deliberately read from stored state, never bypassed.
   always_comb begin
      w_rs_data = '0;
      w_rs_busy = '0;
      for (int k = 0; k < NREAD; k++) begin
         w_rs_data[k*XLEN +: XLEN] = r_regs[bus.rs_addr[k*AW +: AW]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NWRITE; j++) begin
               if (w_wr_ok[j] && (bus.wr_addr[j*AW +: AW] == bus.rs_addr[k*AW +: AW])) begin
                  w_rs_data[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
               end
            end
         end
         if ((ZERO_REG != 0) && (bus.rs_addr[k*AW +: AW] == '0)) begin
            w_rs_data[k*XLEN +: XLEN] = '0;
         end
         w_rs_busy[k] = r_busy[bus.rs_addr[k*AW +: AW]];
      end
   end

   assign bus.rs_data  = w_rs_data;
   assign bus.rs_busy  = w_rs_busy;
   assign bus.busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_file_mp                                                  |
// | Brief    : Directed bench for reg_file_mp across three configurations.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_reg_file_mp;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // ia: default config; ib: BYPASS=0, ZERO_REG=0 mirroring ia's inputs; ic: wide config.
   reg_file_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) ia ();
   reg_file_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) ib ();
   reg_file_mp_if #(.XLEN(64), .NREGS(64), .NREAD(3), .NWRITE(1)) ic ();

   assign ib.rs_addr    = ia.rs_addr;
   assign ib.wr_en      = ia.wr_en;
   assign ib.wr_addr    = ia.wr_addr;
   assign ib.wr_data    = ia.wr_data;
   assign ib.issue_en   = ia.issue_en;
   assign ib.issue_addr = ia.issue_addr;

   reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .reset(reset), .bus(ia));
   reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(0), .BYPASS(0))
      dut_b (.clk(clk), .reset(reset), .bus(ib));
   reg_file_mp #(.XLEN(64), .NREGS(64), .NREAD(3), .NWRITE(1), .ZERO_REG(1), .BYPASS(1))
      dut_c (.clk(clk), .reset(reset), .bus(ic));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ia.wr_en      = '0;
      ia.wr_addr    = '0;
      ia.wr_data    = '0;
      ia.issue_en   = 1'b0;
      ia.issue_addr = '0;
      ic.wr_en      = '0;
      ic.wr_addr    = '0;
      ic.wr_data    = '0;
      ic.issue_en   = 1'b0;
      ic.issue_addr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      ia.rs_addr = '0;
      ic.rs_addr = '0;
      tick();
      tick();
      reset = 1'b0;
      // Some state to be wiped.
      ia.wr_en = 2'b11; ia.wr_addr = {5'd2, 5'd1}; ia.wr_data = {32'h2222_2222, 32'h1111_1111};
      ia.issue_en = 1'b1; ia.issue_addr = 5'd4;
      tick();
      idle();
      ia.rs_addr = {5'd2, 5'd1};
      #1;
      checks++;
      if (ib.rs_data !== {32'h2222_2222, 32'h1111_1111}) begin
         errors++; $display("FAIL pre_reset_data: got %h want %h", ib.rs_data, {32'h2222_2222, 32'h1111_1111});
      end
      reset = 1'b1;
      ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd5}; ia.wr_data = {32'h0, 32'hDEAD_BEEF};
      tick();
      reset = 1'b0;
      idle();
      ia.rs_addr = {5'd5, 5'd1};
      #1;
      checks++;
      if (ia.rs_data !== 64'h0 || ia.busy_vec !== 32'h0 || ia.rs_busy !== 2'b00) begin
         errors++; $display("FAIL reset_a: data %h busy %h want 0", ia.rs_data, ia.busy_vec);
      end
      checks++;
      if (ib.rs_data !== 64'h0 || ib.busy_vec !== 32'h0) begin
         errors++; $display("FAIL reset_b: data %h busy %h want 0", ib.rs_data, ib.busy_vec);
      end
      checks++;
      if (ic.busy_vec !== 64'h0 || ic.rs_data !== 192'h0) begin
         errors++; $display("FAIL reset_c: busy %h data %h want 0", ic.busy_vec, ic.rs_data);
      end
   endtask

   task automatic test_basic_write();
      ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd7}; ia.wr_data = {32'h0, 32'h1234_5678};
      ia.rs_addr = {5'd7, 5'd7};
      #1;
      checks++;
      if (ia.rs_data !== {2{32'h1234_5678}}) begin
         errors++; $display("FAIL bypass_same_cycle: got %h want %h", ia.rs_data, {2{32'h1234_5678}});
      end
      checks++;
      if (ib.rs_data !== 64'h0) begin
         errors++; $display("FAIL nobypass_same_cycle: got %h want 0", ib.rs_data);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ia.rs_data !== {2{32'h1234_5678}} || ib.rs_data !== {2{32'h1234_5678}}) begin
         errors++; $display("FAIL write_read_next: a %h b %h want %h", ia.rs_data, ib.rs_data, {2{32'h1234_5678}});
      end
   endtask

   task automatic test_zero_reg();
      ia.wr_en = 2'b01; ia.wr_addr = '0; ia.wr_data = {32'h0, 32'hFFFF_FFFF};
      ia.issue_en = 1'b1; ia.issue_addr = 5'd0;
      ia.rs_addr = '0;
      #1;
      checks++;
      if (ia.rs_data !== 64'h0) begin
         errors++; $display("FAIL zero_bypass: got %h want 0", ia.rs_data);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ia.rs_data !== 64'h0 || ia.rs_busy !== 2'b00 || ia.busy_vec[0] !== 1'b0) begin
         errors++; $display("FAIL zero_reg: data %h busy %b vec0 %b want 0", ia.rs_data, ia.rs_busy, ia.busy_vec[0]);
      end
      checks++;
      if (ib.rs_data[31:0] !== 32'hFFFF_FFFF || ib.busy_vec[0] !== 1'b1) begin
         errors++; $display("FAIL nonzero_x0: data %h vec0 %b want ffffffff 1", ib.rs_data[31:0], ib.busy_vec[0]);
      end
   endtask

   task automatic test_write_conflict();
      ia.wr_en = 2'b11; ia.wr_addr = {5'd3, 5'd3}; ia.wr_data = {32'h5555, 32'hAAAA};
      ia.rs_addr = {5'd3, 5'd3};
      #1;
      checks++;
      if (ia.rs_data[31:0] !== 32'h5555) begin
         errors++; $display("FAIL conflict_bypass: got %h want 00005555", ia.rs_data[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ia.rs_data[31:0] !== 32'h5555 || ib.rs_data[31:0] !== 32'h5555) begin
         errors++; $display("FAIL conflict_stored: a %h b %h want 00005555", ia.rs_data[31:0], ib.rs_data[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      ia.issue_en = 1'b1; ia.issue_addr = 5'd9;
      ia.rs_addr = {5'd1, 5'd9};
      #1;
      checks++;
      if (ia.rs_busy !== 2'b00) begin
         errors++; $display("FAIL issue_same_cycle: busy %b want 00", ia.rs_busy);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ia.busy_vec !== 32'h0000_0200 || ia.rs_busy !== 2'b01) begin
         errors++; $display("FAIL issue_busy: vec %h rs %b want 00000200 01", ia.busy_vec, ia.rs_busy);
      end
      ia.wr_en = 2'b10; ia.wr_addr = {5'd9, 5'd0}; ia.wr_data = {32'h0000_0099, 32'h0};
      #1;
      checks++;
      if (ia.rs_busy[0] !== 1'b1 || ia.rs_data[31:0] !== 32'h99) begin
         errors++; $display("FAIL wb_same_cycle: busy %b data %h want 1 00000099", ia.rs_busy[0], ia.rs_data[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (ia.busy_vec !== 32'h0 || ia.rs_busy !== 2'b00) begin
         errors++; $display("FAIL wb_clear: vec %h rs %b want 0", ia.busy_vec, ia.rs_busy);
      end
      ia.issue_en = 1'b1; ia.issue_addr = 5'd9;
      ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd9}; ia.wr_data = {32'h0, 32'h0000_0077};
      tick();
      idle();
      #1;
      checks++;
      if (ia.busy_vec[9] !== 1'b1 || ia.rs_data[31:0] !== 32'h77 || ib.rs_data[31:0] !== 32'h77) begin
         errors++; $display("FAIL issue_and_wb: vec9 %b a %h b %h want 1 00000077", ia.busy_vec[9], ia.rs_data[31:0], ib.rs_data[31:0]);
      end
   endtask

   task automatic test_back_to_back();
      ia.wr_en = 2'b11; ia.wr_addr = {5'd11, 5'd10}; ia.wr_data = {32'hB0B0_0011, 32'hA0A0_0010};
      tick();
      ia.wr_addr = {5'd10, 5'd12}; ia.wr_data = {32'hC0C0_0010, 32'hA0A0_0012};
      tick();
      idle();
      ia.rs_addr = {5'd11, 5'd10};
      #1;
      checks++;
      if (ib.rs_data !== {32'hB0B0_0011, 32'hC0C0_0010}) begin
         errors++; $display("FAIL b2b_ports: got %h want %h", ib.rs_data, {32'hB0B0_0011, 32'hC0C0_0010});
      end
      ia.rs_addr = {5'd12, 5'd12};
      #1;
      checks++;
      if (ia.rs_data !== {2{32'hA0A0_0012}}) begin
         errors++; $display("FAIL b2b_x12: got %h want %h", ia.rs_data, {2{32'hA0A0_0012}});
      end
   endtask

   task automatic test_param_sweep();
      ic.wr_en = 1'b1; ic.wr_addr = 6'd63; ic.wr_data = 64'h0123_4567_89AB_CDEF;
      ic.issue_en = 1'b1; ic.issue_addr = 6'd62;
      ic.rs_addr = {6'd63, 6'd63, 6'd63};
      #1;
      checks++;
      if (ic.rs_data !== {3{64'h0123_4567_89AB_CDEF}}) begin
         errors++; $display("FAIL wide_bypass: got %h", ic.rs_data);
      end
      tick();
      idle();
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ic.rs_data[k*64 +: 64] !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL wide_read_port%0d: got %h want 0123456789abcdef", k, ic.rs_data[k*64 +: 64]);
         end
      end
      checks++;
      if (ic.busy_vec !== 64'h4000_0000_0000_0000) begin
         errors++; $display("FAIL wide_busy: got %h want 4000000000000000", ic.busy_vec);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_write_conflict();
      test_scoreboard();
      test_back_to_back();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
